// File: rtl/tuner_ctrl_seq_pkg.sv
// Shared constants, state encoding and helpers for the tuner control sequencer.
package tuner_ctrl_seq_pkg;

  localparam int DAC_WIDTH  = 8;
  localparam int ADC_WIDTH  = 8;
  localparam int NUM_TARGET = 8;
  localparam int MAX_RETRY  = 3;
  localparam int MAX_RESUME = 2;

  localparam int IDX_W    = $clog2(NUM_TARGET);
  localparam int CNT_W    = IDX_W + 1;
  localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
  localparam int RESUME_W = $clog2(MAX_RESUME + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH_TRIG,
    SEARCH_WAIT,
    SELECT,
    LOCK_TRIG,
    LOCKED,
    RESUME,
    ERR
  } tuner_ctrl_state_e;

  // A search engine may report more peaks than the list can hold.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt > CNT_W'(NUM_TARGET)) ? CNT_W'(NUM_TARGET) : cnt;
  endfunction

endpackage

// File: rtl/tuner_ctrl_seq_if.sv
// Handshake and data bundle between the sequencer (master) and search/lock/phy side (slave).
interface tuner_ctrl_seq_if;
  import tuner_ctrl_seq_pkg::*;

  // Every *_val/*_rdy pair: the sender raises val and holds it, with data stable,
  // until val & rdy are both high at a rising clk edge; that edge is the transfer.
  logic                                  start;
  logic                                  sel_mode;
  logic [IDX_W-1:0]                      target_idx;
  logic                                  search_trig_val;
  logic                                  search_trig_rdy;
  logic                                  search_peaks_val;
  logic                                  search_peaks_rdy;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0]  ring_tune_peaks;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0]  pwr_peaks;
  logic [CNT_W-1:0]                      peaks_cnt;
  logic [DAC_WIDTH-1:0]                  cfg_ring_tune_peak;
  logic [ADC_WIDTH-1:0]                  cfg_pwr_peak;
  logic                                  lock_trig_val;
  logic                                  lock_trig_rdy;
  logic                                  lock_intr_val;
  logic                                  lock_intr_rdy;
  logic                                  lock_resume_val;
  logic                                  lock_resume_rdy;
  tuner_ctrl_state_e                     state;
  logic                                  locked;
  logic                                  err;
  logic [RETRY_W-1:0]                    retry_cnt;

  modport master (
    input  start, sel_mode, target_idx, search_trig_rdy, search_peaks_val,
           ring_tune_peaks, pwr_peaks, peaks_cnt, lock_trig_rdy, lock_intr_val,
           lock_resume_rdy,
    output search_trig_val, search_peaks_rdy, cfg_ring_tune_peak, cfg_pwr_peak,
           lock_trig_val, lock_intr_rdy, lock_resume_val, state, locked, err,
           retry_cnt
  );

  modport slave (
    output start, sel_mode, target_idx, search_trig_rdy, search_peaks_val,
           ring_tune_peaks, pwr_peaks, peaks_cnt, lock_trig_rdy, lock_intr_val,
           lock_resume_rdy,
    input  search_trig_val, search_peaks_rdy, cfg_ring_tune_peak, cfg_pwr_peak,
           lock_trig_val, lock_intr_rdy, lock_resume_val, state, locked, err,
           retry_cnt
  );

endinterface

// File: rtl/tuner_ctrl_seq_peak_select.sv
// Combinational peak chooser: fixed index or highest power (lowest index wins ties).
module tuner_peak_select
  import tuner_ctrl_seq_pkg::*;
(
  input  logic                                 sel_mode,
  input  logic [IDX_W-1:0]                     target_idx,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_peaks,
  input  logic [CNT_W-1:0]                     cnt,
  output logic                                 hit,
  output logic [DAC_WIDTH-1:0]                 tune,
  output logic [ADC_WIDTH-1:0]                 pwr
);

  logic [IDX_W-1:0]     pick;
  logic                 found;
  logic [ADC_WIDTH-1:0] best;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    best  = '0;
    if (!sel_mode) begin
      found = ({1'b0, target_idx} < cnt);
      pick  = target_idx;
    end else begin
      // Strict '>' keeps the earliest entry when powers tie.
      for (int i = 0; i < NUM_TARGET; i++) begin
        if ((CNT_W'(i) < cnt) && (!found || (pwr_peaks[i] > best))) begin
          found = 1'b1;
          best  = pwr_peaks[i];
          pick  = IDX_W'(i);
        end
      end
    end
  end

  assign hit  = found;
  assign tune = tune_peaks[pick];
  assign pwr  = pwr_peaks[pick];

endmodule

// File: rtl/tuner_ctrl_seq.sv
// Search -> select -> lock sequencer feeding tuner_phy, with bounded resume and re-search.
module tuner_ctrl_seq
  import tuner_ctrl_seq_pkg::*;
(
  input logic              clk,
  input logic              rst,
  tuner_ctrl_seq_if.master bus
);

  tuner_ctrl_state_e                    state;
  logic                                 search_trig_val;
  logic                                 search_peaks_rdy;
  logic                                 lock_trig_val;
  logic                                 lock_intr_rdy;
  logic                                 lock_resume_val;
  logic                                 locked;
  logic                                 err;
  logic [DAC_WIDTH-1:0]                 cfg_tune;
  logic [ADC_WIDTH-1:0]                 cfg_pwr;
  logic [RETRY_W-1:0]                   retry_cnt;
  logic [RESUME_W-1:0]                  resume_cnt;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] cap_tune;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] cap_pwr;
  logic [CNT_W-1:0]                     cap_cnt;
  logic                                 sel_hit;
  logic [DAC_WIDTH-1:0]                 sel_tune;
  logic [ADC_WIDTH-1:0]                 sel_pwr;
  logic [RETRY_W-1:0]                   retry_next;

  assign retry_next = retry_cnt + RETRY_W'(1);

  tuner_peak_select u_sel (
    .sel_mode   (bus.sel_mode),
    .target_idx (bus.target_idx),
    .tune_peaks (cap_tune),
    .pwr_peaks  (cap_pwr),
    .cnt        (cap_cnt),
    .hit        (sel_hit),
    .tune       (sel_tune),
    .pwr        (sel_pwr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      search_trig_val  <= 1'b0;
      search_peaks_rdy <= 1'b0;
      lock_trig_val    <= 1'b0;
      lock_intr_rdy    <= 1'b0;
      lock_resume_val  <= 1'b0;
      locked           <= 1'b0;
      err              <= 1'b0;
      cfg_tune         <= '0;
      cfg_pwr          <= '0;
      retry_cnt        <= '0;
      resume_cnt       <= '0;
      cap_tune         <= '0;
      cap_pwr          <= '0;
      cap_cnt          <= '0;
    end else begin
      case (state)
        IDLE, ERR: begin
          if (bus.start) begin
            state           <= SEARCH_TRIG;
            search_trig_val <= 1'b1;
            err             <= 1'b0;
            retry_cnt       <= '0;
            resume_cnt      <= '0;
          end
        end
        SEARCH_TRIG: begin
          if (bus.search_trig_rdy) begin
            state            <= SEARCH_WAIT;
            search_trig_val  <= 1'b0;
            search_peaks_rdy <= 1'b1;
          end
        end
        SEARCH_WAIT: begin
          if (bus.search_peaks_val) begin
            state            <= SELECT;
            search_peaks_rdy <= 1'b0;
            cap_tune         <= bus.ring_tune_peaks;
            cap_pwr          <= bus.pwr_peaks;
            cap_cnt          <= clamp_cnt(bus.peaks_cnt);
          end
        end
        SELECT: begin
          if (sel_hit) begin
            state         <= LOCK_TRIG;
            lock_trig_val <= 1'b1;
            cfg_tune      <= sel_tune;
            cfg_pwr       <= sel_pwr;
          end else if (retry_next == RETRY_W'(MAX_RETRY)) begin
            state     <= ERR;
            err       <= 1'b1;
            retry_cnt <= retry_next;
          end else begin
            state           <= SEARCH_TRIG;
            search_trig_val <= 1'b1;
            retry_cnt       <= retry_next;
          end
        end
        LOCK_TRIG: begin
          if (bus.lock_trig_rdy) begin
            state         <= LOCKED;
            lock_trig_val <= 1'b0;
            lock_intr_rdy <= 1'b1;
            locked        <= 1'b1;
            retry_cnt     <= '0;
          end
        end
        LOCKED: begin
          // A lost lock takes priority over a simultaneous re-acquire request.
          if (bus.lock_intr_val) begin
            lock_intr_rdy <= 1'b0;
            locked        <= 1'b0;
            if (resume_cnt < RESUME_W'(MAX_RESUME)) begin
              state           <= RESUME;
              lock_resume_val <= 1'b1;
              resume_cnt      <= resume_cnt + RESUME_W'(1);
            end else begin
              state           <= SEARCH_TRIG;
              search_trig_val <= 1'b1;
              resume_cnt      <= '0;
            end
          end else if (bus.start) begin
            state           <= SEARCH_TRIG;
            search_trig_val <= 1'b1;
            lock_intr_rdy   <= 1'b0;
            locked          <= 1'b0;
            resume_cnt      <= '0;
          end
        end
        RESUME: begin
          if (bus.lock_resume_rdy) begin
            state           <= LOCKED;
            lock_resume_val <= 1'b0;
            lock_intr_rdy   <= 1'b1;
            locked          <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.state              = state;
  assign bus.search_trig_val    = search_trig_val;
  assign bus.search_peaks_rdy   = search_peaks_rdy;
  assign bus.lock_trig_val      = lock_trig_val;
  assign bus.lock_intr_rdy      = lock_intr_rdy;
  assign bus.lock_resume_val    = lock_resume_val;
  assign bus.locked             = locked;
  assign bus.err                = err;
  assign bus.cfg_ring_tune_peak = cfg_tune;
  assign bus.cfg_pwr_peak       = cfg_pwr;
  assign bus.retry_cnt          = retry_cnt;

endmodule

// File: tb/tb_tuner_ctrl_seq.sv
// Bench for tuner_ctrl_seq: vector table, directed multi-cycle sequences, random lists vs model.
module tb_tuner_ctrl_seq;
  import tuner_ctrl_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  logic [15:0] exp_q[$];
  logic [7:0][7:0] tv;
  logic [7:0][7:0] pv;

  tuner_ctrl_seq_if bus();

  tuner_ctrl_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mode;
    logic [2:0] idx;
    logic [3:0] cnt;
    int         pat;
    logic       hit;
    logic [7:0] tune;
    logic [7:0] pwr;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.start            = 1'b0;
    bus.sel_mode         = 1'b0;
    bus.target_idx       = '0;
    bus.search_trig_rdy  = 1'b0;
    bus.search_peaks_val = 1'b0;
    bus.ring_tune_peaks  = '0;
    bus.pwr_peaks        = '0;
    bus.peaks_cnt        = '0;
    bus.lock_trig_rdy    = 1'b0;
    bus.lock_intr_val    = 1'b0;
    bus.lock_resume_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Completes one search round trip; returns at the negedge where the DUT sits in SELECT.
  task automatic serve_search(input logic mode, input logic [2:0] idx, input logic [3:0] cnt,
                              input int stall);
    int n;
    n = 0;
    while (!bus.search_trig_val && n < 20) begin
      tick(1);
      n++;
    end
    check("search_trig_wait", bus.search_trig_val, 1);
    tick(stall);
    bus.sel_mode        = mode;
    bus.target_idx      = idx;
    bus.ring_tune_peaks = tv;
    bus.pwr_peaks       = pv;
    bus.peaks_cnt       = cnt;
    bus.search_trig_rdy = 1'b1;
    tick(1);
    bus.search_trig_rdy = 1'b0;
    n = 0;
    while (!bus.search_peaks_rdy && n < 20) begin
      tick(1);
      n++;
    end
    check("peaks_rdy_wait", bus.search_peaks_rdy, 1);
    bus.search_peaks_val = 1'b1;
    tick(1);
    bus.search_peaks_val = 1'b0;
  endtask

  task automatic accept_lock();
    bus.lock_trig_rdy = 1'b1;
    tick(1);
    bus.lock_trig_rdy = 1'b0;
  endtask

  function automatic logic [7:0] pat_pwr(input int p, input int i);
    logic [7:0] p1 [8];
    p1 = '{8'd200, 8'd40, 8'd200, 8'd40, 8'd40, 8'd40, 8'd40, 8'd250};
    if (p == 0) return 8'(50 + 10 * i);
    if (p == 1) return p1[i];
    return 8'd77;
  endfunction

  task automatic load_pattern(input int p);
    for (int i = 0; i < 8; i++) begin
      tv[i] = 8'(10 + 20 * i);
      pv[i] = pat_pwr(p, i);
    end
  endtask

  // Reference choice: clamp the count, then take the index or the first occurrence of the maximum.
  function automatic void ref_pick(input logic mode, input logic [2:0] idx, input logic [3:0] cnt,
                                   output logic hit, output logic [7:0] t, output logic [7:0] p);
    int n;
    int maxv;
    n = (cnt > 8) ? 8 : int'(cnt);
    hit = 1'b0;
    t = '0;
    p = '0;
    if (n == 0) return;
    if (!mode) begin
      if (int'(idx) < n) begin
        hit = 1'b1;
        t = tv[idx];
        p = pv[idx];
      end
      return;
    end
    maxv = -1;
    for (int i = 0; i < n; i++) if (int'(pv[i]) > maxv) maxv = int'(pv[i]);
    for (int i = 0; i < n; i++) begin
      if (!hit && int'(pv[i]) == maxv) begin
        hit = 1'b1;
        t = tv[i];
        p = pv[i];
      end
    end
  endfunction

  initial begin
    logic       m_hit;
    logic [7:0] m_t;
    logic [7:0] m_p;
    logic       r_mode;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;

    tbl[0]  = '{1'b0, 3'd2, 4'd3,  0, 1'b1, 8'd50,  8'd70};
    tbl[1]  = '{1'b0, 3'd3, 4'd3,  0, 1'b0, 8'd0,   8'd0};
    tbl[2]  = '{1'b0, 3'd0, 4'd0,  0, 1'b0, 8'd0,   8'd0};
    tbl[3]  = '{1'b1, 3'd0, 4'd0,  1, 1'b0, 8'd0,   8'd0};
    tbl[4]  = '{1'b1, 3'd0, 4'd5,  1, 1'b1, 8'd10,  8'd200};
    tbl[5]  = '{1'b1, 3'd0, 4'd8,  1, 1'b1, 8'd150, 8'd250};
    tbl[6]  = '{1'b1, 3'd0, 4'd15, 1, 1'b1, 8'd150, 8'd250};
    tbl[7]  = '{1'b0, 3'd7, 4'd9,  0, 1'b1, 8'd150, 8'd120};
    tbl[8]  = '{1'b1, 3'd0, 4'd4,  0, 1'b1, 8'd70,  8'd80};
    tbl[9]  = '{1'b1, 3'd0, 4'd3,  2, 1'b1, 8'd10,  8'd77};
    tbl[10] = '{1'b0, 3'd7, 4'd7,  0, 1'b0, 8'd0,   8'd0};

    tv = '0;
    pv = '0;
    clear_inputs();
    tick(2);
    // Reset state
    check("rst_state", int'(bus.state), int'(IDLE));
    check("rst_trig_val", bus.search_trig_val, 0);
    check("rst_peaks_rdy", bus.search_peaks_rdy, 0);
    check("rst_lock_val", bus.lock_trig_val, 0);
    check("rst_cfg", {bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}, 0);
    check("rst_flags", {bus.locked, bus.err, bus.retry_cnt, bus.lock_intr_rdy, bus.lock_resume_val}, 0);
    rst = 1'b0;
    tick(1);

    // Directed: max-power pick with a tie, latency and stall behaviour
    start_pulse();
    check("start_lat_val", bus.search_trig_val, 1);
    check("start_lat_state", int'(bus.state), int'(SEARCH_TRIG));
    bus.lock_intr_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1;
      tick(1);
      check("trig_stall_val", bus.search_trig_val, 1);
      check("trig_stall_state", int'(bus.state), int'(SEARCH_TRIG));
      check("intr_rdy_off", bus.lock_intr_rdy, 0);
    end
    bus.start = 1'b0;
    bus.lock_intr_val = 1'b0;
    tv = '0;
    pv = '0;
    tv[0] = 8'd20;  tv[1] = 8'd80;  tv[2] = 8'd140;
    pv[0] = 8'd90;  pv[1] = 8'd200; pv[2] = 8'd200;
    serve_search(1'b1, 3'd0, 4'd3, 0);
    check("sel_lock_val_early", bus.lock_trig_val, 0);
    tick(1);
    check("lock_lat_val", bus.lock_trig_val, 1);
    check("dir_cfg_tune", bus.cfg_ring_tune_peak, 80);
    check("dir_cfg_pwr", bus.cfg_pwr_peak, 200);
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1;
      tick(1);
      check("lock_stall_val", bus.lock_trig_val, 1);
      check("lock_stall_state", int'(bus.state), int'(LOCK_TRIG));
    end
    bus.start = 1'b0;
    accept_lock();
    check("locked_state", int'(bus.state), int'(LOCKED));
    check("locked_flag", bus.locked, 1);

    // Three lock-lost interrupts: two resumes then a full re-search
    for (int k = 1; k <= 3; k++) begin
      check("intr_rdy", bus.lock_intr_rdy, 1);
      bus.lock_intr_val = 1'b1;
      tick(1);
      bus.lock_intr_val = 1'b0;
      if (k < 3) begin
        check("resume_state", int'(bus.state), int'(RESUME));
        check("resume_val", bus.lock_resume_val, 1);
        check("resume_cfg", bus.cfg_ring_tune_peak, 80);
        bus.lock_resume_rdy = 1'b1;
        tick(1);
        bus.lock_resume_rdy = 1'b0;
        check("relocked", int'(bus.state), int'(LOCKED));
      end else begin
        check("research_state", int'(bus.state), int'(SEARCH_TRIG));
        check("research_val", bus.search_trig_val, 1);
        check("research_locked", bus.locked, 0);
      end
    end

    // Async reset while a lock trigger is pending
    serve_search(1'b1, 3'd0, 4'd3, 1);
    tick(1);
    check("pre_rst_lock_val", bus.lock_trig_val, 1);
    rst = 1'b1;
    #1;
    check("async_rst_state", int'(bus.state), int'(IDLE));
    check("async_rst_outs", {bus.lock_trig_val, bus.search_trig_val, bus.search_peaks_rdy,
                             bus.locked, bus.err, bus.retry_cnt}, 0);
    check("async_rst_cfg", {bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Index out of range three times -> ERR, then restart
    load_pattern(0);
    start_pulse();
    for (int r = 1; r <= 3; r++) begin
      serve_search(1'b0, 3'd5, 4'd3, 0);
      tick(1);
      check("retry_cnt", bus.retry_cnt, r);
      if (r < 3) begin
        check("retry_state", int'(bus.state), int'(SEARCH_TRIG));
        check("retry_err", bus.err, 0);
      end else begin
        check("err_state", int'(bus.state), int'(ERR));
        check("err_flag", bus.err, 1);
      end
    end
    tick(3);
    check("err_sticky", bus.err, 1);
    start_pulse();
    check("err_restart_state", int'(bus.state), int'(SEARCH_TRIG));
    check("err_cleared", bus.err, 0);
    check("err_retry_cleared", bus.retry_cnt, 0);

    // Two empty lists, then a good one: retry counter clears on lock
    for (int r = 1; r <= 2; r++) begin
      serve_search(1'b1, 3'd0, 4'd0, 0);
      tick(1);
      check("empty_retry", bus.retry_cnt, r);
    end
    serve_search(1'b1, 3'd0, 4'd2, 0);
    tick(1);
    check("empty_then_tune", bus.cfg_ring_tune_peak, 30);
    check("empty_then_pwr", bus.cfg_pwr_peak, 60);
    accept_lock();
    check("empty_then_locked", int'(bus.state), int'(LOCKED));
    check("empty_then_retry0", bus.retry_cnt, 0);

    // Vector table
    for (int v = 0; v < 11; v++) begin
      do_reset();
      load_pattern(tbl[v].pat);
      start_pulse();
      serve_search(tbl[v].mode, tbl[v].idx, tbl[v].cnt, 0);
      tick(1);
      if (tbl[v].hit) begin
        check("tbl_state_hit", int'(bus.state), int'(LOCK_TRIG));
        check("tbl_tune", bus.cfg_ring_tune_peak, int'(tbl[v].tune));
        check("tbl_pwr", bus.cfg_pwr_peak, int'(tbl[v].pwr));
      end else begin
        check("tbl_state_miss", int'(bus.state), int'(SEARCH_TRIG));
        check("tbl_retry", bus.retry_cnt, 1);
        check("tbl_cfg_kept", bus.cfg_ring_tune_peak, 0);
      end
    end

    // Random lists against the reference model
    for (int it = 0; it < 40; it++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        tv[i] = 8'($urandom_range(0, 255));
        pv[i] = 8'($urandom_range(0, 3) * 64);
      end
      r_mode = 1'($urandom_range(0, 1));
      r_idx  = 3'($urandom_range(0, 7));
      r_cnt  = 4'($urandom_range(0, 10));
      ref_pick(r_mode, r_idx, r_cnt, m_hit, m_t, m_p);
      if (m_hit) exp_q.push_back({m_t, m_p});
      start_pulse();
      serve_search(r_mode, r_idx, r_cnt, $urandom_range(0, 3));
      tick(1);
      check("rnd_lock_val", bus.lock_trig_val, m_hit);
      if (bus.lock_trig_val && exp_q.size() > 0)
        check("rnd_cfg", {bus.cfg_ring_tune_peak, bus.cfg_pwr_peak}, exp_q.pop_front());
      else
        check("rnd_retry", bus.retry_cnt, m_hit ? 0 : 1);
    end
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
